// File: rtl/pc_fetch.sv
// Fetch-stage PC owner: selects the next PC, registers it, and loads the IF/ID
// pipeline register. Freezes in an error state on an illegal fetch address.
module pc_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int          IM_ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        fetch_err
);

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_ERR = 1'b1;

  // Upper bound kept at 33 bits so a memory ending exactly at 2**32 does not wrap.
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'd4 << IM_ADDR_BITS);

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  logic [31:0] npc;
  logic        npc_illegal;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  always_comb begin
    npc = pc_plus4;
    case (npc_sel)
      SEL_SEQ: npc = pc_plus4;
      SEL_BR:  npc = br_taken ? br_target : pc_plus4;
      SEL_J:   npc = j_target;
      SEL_JR:  npc = jr_target;
      default: npc = pc_plus4;
    endcase
  end

  assign npc_illegal = (npc[1:0] != 2'b00)
                     || (npc < RESET_PC)
                     || ({1'b0, npc} >= PC_LIMIT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        // Stall freezes everything, including evaluation of the next PC.
        if (!stall) begin
          if (npc_illegal) begin
            valid_d = 1'b0;
            err_d   = 1'b1;
            state_d = ST_ERR;
          end else begin
            pc_d    = npc;
            instr_d = im_rdata;
            pc4_d   = pc_plus4;
            pc8_d   = pc_plus8;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      pc8_q   <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign pc        = pc_q;
  assign id_instr  = instr_q;
  assign id_pc4    = pc4_q;
  assign id_pc8    = pc8_q;
  assign id_valid  = valid_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a reference model pushes expected IF state into a
// scoreboard queue each step, and the queue is popped after every clock edge.
module tb_pc_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic        valid;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default base 0x3000
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0, j_target = 32'd0, jr_target = 32'd0;
  logic [31:0] im_rdata, pc, id_instr, id_pc4, id_pc8;
  logic        id_valid, fetch_err;

  // Instance 2: base at the top of the address space, to exercise the wrap
  logic        reset2 = 1'b0;
  logic        stall2 = 1'b0;
  logic [1:0]  npc_sel2 = 2'b00;
  logic        br_taken2 = 1'b0;
  logic [31:0] br_target2 = 32'd0, j_target2 = 32'd0, jr_target2 = 32'd0;
  logic [31:0] im_rdata2, pc2, id_instr2, id_pc42, id_pc82;
  logic        id_valid2, fetch_err2;

  function automatic logic [31:0] imf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign im_rdata  = imf(pc);
  assign im_rdata2 = imf(pc2);

  pc_fetch #(.RESET_PC(32'h0000_3000), .IM_ADDR_BITS(10)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel), .br_taken(br_taken),
    .br_target(br_target), .j_target(j_target), .jr_target(jr_target),
    .im_rdata(im_rdata), .pc(pc), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_pc8(id_pc8), .id_valid(id_valid), .fetch_err(fetch_err)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_F000), .IM_ADDR_BITS(10)) dut2 (
    .clk(clk), .reset(reset2), .stall(stall2), .npc_sel(npc_sel2), .br_taken(br_taken2),
    .br_target(br_target2), .j_target(j_target2), .jr_target(jr_target2),
    .im_rdata(im_rdata2), .pc(pc2), .id_instr(id_instr2), .id_pc4(id_pc42),
    .id_pc8(id_pc82), .id_valid(id_valid2), .fetch_err(fetch_err2)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t m;  // reference model of instance 1

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [32:0] LIMIT = 33'h0_0000_4000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic compare_pop(input string tag, input exp_t obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed empty-scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc"},    obs.pc,    e.pc);
      chk({tag, ".instr"}, obs.instr, e.instr);
      chk({tag, ".pc4"},   obs.pc4,   e.pc4);
      chk({tag, ".pc8"},   obs.pc8,   e.pc8);
      chk({tag, ".valid"}, {31'd0, obs.valid}, {31'd0, e.valid});
      chk({tag, ".err"},   {31'd0, obs.err},   {31'd0, e.err});
      $display("txn %-12s pc=%h instr=%h pc4=%h pc8=%h v=%b err=%b",
               tag, obs.pc, obs.instr, obs.pc4, obs.pc8, obs.valid, obs.err);
    end
  endtask

  function automatic exp_t obs1();
    return {pc, id_instr, id_pc4, id_pc8, id_valid, fetch_err};
  endfunction

  function automatic exp_t obs2();
    return {pc2, id_instr2, id_pc42, id_pc82, id_valid2, fetch_err2};
  endfunction

  function automatic exp_t reset_exp(input logic [31:0] base);
    return {base, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0};
  endfunction

  // Reference behaviour of one clock edge for instance 1.
  task automatic model_edge();
    logic [31:0] nxt;
    if (m.err) begin
      m.valid = 1'b0;
    end else if (!stall) begin
      case (npc_sel)
        2'b01:   nxt = br_taken ? br_target : m.pc + 32'd4;
        2'b10:   nxt = j_target;
        2'b11:   nxt = jr_target;
        default: nxt = m.pc + 32'd4;
      endcase
      if (nxt[1:0] != 2'b00 || nxt < BASE || {1'b0, nxt} >= LIMIT) begin
        m.valid = 1'b0;
        m.err   = 1'b1;
      end else begin
        m.instr = imf(m.pc);
        m.pc4   = m.pc + 32'd4;
        m.pc8   = m.pc + 32'd8;
        m.pc    = nxt;
        m.valid = 1'b1;
      end
    end
  endtask

  task automatic step(input string tag, input logic s, input logic [1:0] sel,
                      input logic tk, input logic [31:0] bt, input logic [31:0] jt,
                      input logic [31:0] jrt);
    stall = s; npc_sel = sel; br_taken = tk;
    br_target = bt; j_target = jt; jr_target = jrt;
    model_edge();
    sb.push_back(m);
    @(posedge clk); #1;
    compare_pop(tag, obs1());
  endtask

  // Asserts reset between edges, checks the immediate clear, releases after an edge.
  task automatic pulse_reset1(input string tag);
    #2;
    reset = 1'b0;
    #1;
    m = reset_exp(BASE);
    sb.push_back(m);
    compare_pop(tag, obs1());
    @(posedge clk); #1;
    reset = 1'b1;
    stall = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    m = reset_exp(BASE);
    sb.push_back(m);
    compare_pop("reset", obs1());
    reset = 1'b1;

    step("seq0",      0, 2'b00, 0, 32'h0,    32'h0,    32'h0);
    step("seq1",      0, 2'b00, 0, 32'h0,    32'h0,    32'h0);
    step("br_taken",  0, 2'b01, 1, 32'h3020, 32'h0,    32'h0);
    step("br_ntaken", 0, 2'b01, 0, 32'h3200, 32'h0,    32'h0);
    step("jump",      0, 2'b10, 0, 32'h0,    32'h3100, 32'h0);
    step("stall0",    1, 2'b11, 0, 32'h0,    32'h0,    32'h3040);
    step("stall1",    1, 2'b11, 0, 32'h0,    32'h0,    32'h3040);
    step("jr",        0, 2'b11, 0, 32'h0,    32'h0,    32'h3040);
    step("jr_misal",  0, 2'b11, 0, 32'h0,    32'h0,    32'h3042);
    step("err_jr",    0, 2'b11, 0, 32'h0,    32'h0,    32'h3080);
    step("err_j",     0, 2'b10, 0, 32'h0,    32'h3100, 32'h0);
    step("err_stall", 1, 2'b00, 0, 32'h0,    32'h0,    32'h0);
    pulse_reset1("rst_in_err");

    step("low_bound", 0, 2'b11, 0, 32'h0,    32'h0,    32'h2FFC);
    pulse_reset1("rst_low");

    step("base_jr",   0, 2'b11, 0, 32'h0,    32'h0,    32'h3000);
    step("top_word",  0, 2'b11, 0, 32'h0,    32'h0,    32'h3FFC);
    step("past_top",  0, 2'b00, 0, 32'h0,    32'h0,    32'h0);
    pulse_reset1("rst_top");

    step("seq_a",     0, 2'b00, 0, 32'h0,    32'h0,    32'h0);
    step("stall_mid", 1, 2'b10, 0, 32'h0,    32'h3100, 32'h0);
    pulse_reset1("rst_stall");
    step("after_rst", 0, 2'b00, 0, 32'h0,    32'h0,    32'h0);

    // Instance 2: top-of-memory wrap is illegal
    sb.push_back(reset_exp(32'hFFFF_F000));
    compare_pop("r2_reset", obs2());
    reset2 = 1'b1;
    npc_sel2 = 2'b10; j_target2 = 32'hFFFF_FFF8;
    sb.push_back({32'hFFFF_FFF8, imf(32'hFFFF_F000), 32'hFFFF_F004, 32'hFFFF_F008, 1'b1, 1'b0});
    @(posedge clk); #1;
    compare_pop("r2_jump", obs2());
    npc_sel2 = 2'b00;
    sb.push_back({32'hFFFF_FFFC, imf(32'hFFFF_FFF8), 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0});
    @(posedge clk); #1;
    compare_pop("r2_seq", obs2());
    sb.push_back({32'hFFFF_FFFC, imf(32'hFFFF_FFF8), 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1});
    @(posedge clk); #1;
    compare_pop("r2_wrap", obs2());
    sb.push_back({32'hFFFF_FFFC, imf(32'hFFFF_FFF8), 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1});
    @(posedge clk); #1;
    compare_pop("r2_hold", obs2());
    #2;
    reset2 = 1'b0;
    #1;
    sb.push_back(reset_exp(32'hFFFF_F000));
    compare_pop("r2_async", obs2());

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
